// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the pattern sequencer
// Purpose: FSM state encoding, pattern geometry and the symbol-to-LED decode.
// Ports:   none (package).
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHOW_ON  = 3'd1,
      ST_SHOW_OFF = 3'd2,
      ST_WAIT_IN  = 3'd3,
      ST_WIN      = 3'd4,
      ST_LOSE     = 3'd5
   } state_t;

   localparam int NUM_SYMBOLS = 4;
   localparam int SYM_W       = 2;
   localparam int PAT_W       = NUM_SYMBOLS * SYM_W;

   // Symbol s lights LED s.
   function automatic logic [3:0] sym_onehot(input logic [SYM_W-1:0] sym);
      return 4'b0001 << sym;
   endfunction

   // Symbol i from the packed pattern register.
   function automatic logic [SYM_W-1:0] sym_at(input logic [PAT_W-1:0] pat,
                                               input logic [1:0]       i);
      return pat[{i, 1'b0} +: SYM_W];
   endfunction

endpackage

// File: rtl/pattern_sequencer_phase_timer.sv
// rtl/pattern_sequencer_phase_timer.sv - loadable saturating phase counter
// Purpose: up-counter shared by the ON, OFF and input-timeout phases; tc is
//          high while the count equals the runtime limit.
// Ports:   clk, reset (async, active-high); clear, load/load_val, enable
//          control the count; limit is the terminal value; tc is the compare.
module phase_timer #(
   parameter int W = 28
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] count;

   // Counting stops at the limit, so the counter can never wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (enable && !tc)
         count <= count + W'(1);
   end

   assign tc = (count == limit);

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - memory-game pattern playback and input checker
// Purpose: snapshots a random word on start, plays four symbols on the LEDs,
//          then checks the player's presses and reports win or lose.
// Ports:   clk, reset (async, active-high); start pulse; random_num word;
//          btn press pulses; led display; busy / expect_input phase flags;
//          step_idx current symbol; win / lose held results.
module pattern_sequencer
   import game_pkg::*;
#(
   parameter int ON_CYCLES      = 25_000_000,
   parameter int OFF_CYCLES     = 12_500_000,
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int TIMER_W        = 28
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] random_num,
   input  logic [3:0]  btn,
   output logic [3:0]  led,
   output logic        busy,
   output logic        expect_input,
   output logic [1:0]  step_idx,
   output logic        win,
   output logic        lose
);

   state_t             state;
   logic [PAT_W-1:0]   pattern;
   logic [PAT_W-1:0]   capture;
   logic [1:0]         idx;
   logic [3:0]         cur_onehot;
   logic               timer_clear;
   logic               timer_en;
   logic [TIMER_W-1:0] timer_limit;
   logic               timer_tc;
   logic               unused_random;

   // Low two bits of each byte form the symbols; the rest of the word is unused.
   assign capture = {random_num[25:24], random_num[17:16],
                     random_num[9:8],   random_num[1:0]};
   assign unused_random = ^{random_num[31:26], random_num[23:18],
                            random_num[15:10], random_num[7:2]};

   assign cur_onehot = sym_onehot(sym_at(pattern, idx));
   assign step_idx   = idx;

   always_comb begin
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      timer_limit = '0;
      case (state)
         ST_SHOW_ON: begin
            timer_limit = TIMER_W'(ON_CYCLES - 1);
            timer_clear = timer_tc;
            timer_en    = !timer_tc;
         end
         ST_SHOW_OFF: begin
            timer_limit = TIMER_W'(OFF_CYCLES - 1);
            timer_clear = timer_tc;
            timer_en    = !timer_tc;
         end
         ST_WAIT_IN: begin
            // Any press restarts the inter-press timeout.
            timer_limit = TIMER_W'(TIMEOUT_CYCLES - 1);
            timer_clear = (btn != 4'b0000);
            timer_en    = (btn == 4'b0000);
         end
         default: timer_clear = start;
      endcase
   end

   phase_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .load     (1'b0),
      .load_val ('0),
      .enable   (timer_en),
      .limit    (timer_limit),
      .tc       (timer_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         pattern      <= '0;
         idx          <= 2'd0;
         led          <= 4'b0000;
         busy         <= 1'b0;
         expect_input <= 1'b0;
         win          <= 1'b0;
         lose         <= 1'b0;
      end else begin
         case (state)
            ST_SHOW_ON: begin
               if (timer_tc) begin
                  led   <= 4'b0000;
                  state <= ST_SHOW_OFF;
               end
            end
            ST_SHOW_OFF: begin
               if (timer_tc) begin
                  if (idx == 2'd3) begin
                     idx          <= 2'd0;
                     expect_input <= 1'b1;
                     state        <= ST_WAIT_IN;
                  end else begin
                     idx   <= idx + 2'd1;
                     led   <= sym_onehot(sym_at(pattern, idx + 2'd1));
                     state <= ST_SHOW_ON;
                  end
               end
            end
            ST_WAIT_IN: begin
               // A press takes priority over a timeout on the same cycle.
               if (btn != 4'b0000) begin
                  if (btn == cur_onehot) begin
                     if (idx == 2'd3) begin
                        win          <= 1'b1;
                        busy         <= 1'b0;
                        expect_input <= 1'b0;
                        state        <= ST_WIN;
                     end else begin
                        idx <= idx + 2'd1;
                     end
                  end else begin
                     lose         <= 1'b1;
                     busy         <= 1'b0;
                     expect_input <= 1'b0;
                     state        <= ST_LOSE;
                  end
               end else if (timer_tc) begin
                  lose         <= 1'b1;
                  busy         <= 1'b0;
                  expect_input <= 1'b0;
                  state        <= ST_LOSE;
               end
            end
            default: begin
               // IDLE, WIN and LOSE all accept a new round.
               if (start) begin
                  pattern <= capture;
                  idx     <= 2'd0;
                  win     <= 1'b0;
                  lose    <= 1'b0;
                  busy    <= 1'b1;
                  led     <= sym_onehot(capture[SYM_W-1:0]);
                  state   <= ST_SHOW_ON;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
`timescale 1ns/1ps
module tb_pattern_sequencer;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int TO  = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] random_num = 32'h0;
   logic [3:0]  btn = 4'b0000;
   logic [3:0]  led;
   logic        busy;
   logic        expect_input;
   logic [1:0]  step_idx;
   logic        win;
   logic        lose;

   int n_checks = 0;
   int n_pass   = 0;

   pattern_sequencer #(
      .ON_CYCLES      (ON),
      .OFF_CYCLES     (OFF),
      .TIMEOUT_CYCLES (TO),
      .TIMER_W        (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .random_num   (random_num),
      .btn          (btn),
      .led          (led),
      .busy         (busy),
      .expect_input (expect_input),
      .step_idx     (step_idx),
      .win          (win),
      .lose         (lose)
   );

   always #5 clk = ~clk;

   // {led, busy, expect_input, step_idx, win, lose}
   function automatic logic [31:0] stat();
      return 32'({led, busy, expect_input, step_idx, win, lose});
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_round(input logic [31:0] rn);
      random_num = rn;
      start = 1'b1;
      tick();
      start = 1'b0;
      random_num = 32'hFFFF_FFFF;
   endtask

   // leds holds the expected LED for symbol k in bits [4k+3:4k].
   task automatic play(input logic [15:0] leds, input bit noise);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < ON; c++) begin
            check($sformatf("on_led_s%0d_c%0d", k, c), 32'(led), 32'(leds[4*k +: 4]));
            if (c == 0) begin
               check($sformatf("on_flags_s%0d", k), 32'({busy, expect_input, win, lose}), 32'b1000);
               check($sformatf("on_idx_s%0d", k), 32'(step_idx), k);
            end
            if (noise && c == 1) begin
               btn   = 4'b1111;
               start = 1'b1;
            end
            tick();
            btn   = 4'b0000;
            start = 1'b0;
         end
         for (int c = 0; c < OFF; c++) begin
            check($sformatf("off_led_s%0d_c%0d", k, c), 32'(led), 32'h0);
            if (noise && c == 0) begin
               btn   = leds[4*k +: 4];
               start = 1'b1;
            end
            tick();
            btn   = 4'b0000;
            start = 1'b0;
         end
      end
      check("wait_entry", stat(), 32'b0000_1_1_00_0_0);
   endtask

   task automatic press(input logic [3:0] b, input int gap);
      repeat (gap) tick();
      btn = b;
      tick();
      btn = 4'b0000;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", stat(), 32'h0);
      reset = 1'b0;
      tick();
      check("idle_after_reset", stat(), 32'h0);

      // Playback with random_num changing after the capture
      start_round(32'hC302_8140);
      play(16'b1000_0100_0010_0001, 1'b0);

      // Correct entry with assorted gaps
      press(4'b0001, 3);
      check("ok_press1_idx", 32'(step_idx), 32'd1);
      press(4'b0010, 0);
      check("ok_press2_idx", 32'(step_idx), 32'd2);
      press(4'b0100, 10);
      check("ok_press3", stat(), 32'b0000_1_1_11_0_0);
      press(4'b1000, 5);
      check("win_state", stat(), 32'b0000_0_0_11_1_0);
      repeat (3) tick();
      check("win_held", stat(), 32'b0000_0_0_11_1_0);

      // Start from WIN, with btn/start noise during playback
      start_round(32'h0000_0003);
      check("win_cleared", 32'({win, lose}), 32'b00);
      play(16'b0001_0001_0001_1000, 1'b1);

      // Two-bit press at step 0
      press(4'b0011, 2);
      check("lose_multi_bit", stat(), 32'b0000_0_0_00_0_1);

      // Wrong second press
      start_round(32'hC302_8140);
      play(16'b1000_0100_0010_0001, 1'b0);
      press(4'b0001, 1);
      press(4'b0100, 1);
      check("lose_wrong_press", stat(), 32'b0000_0_0_01_0_1);

      // Timeout exactly TO cycles after entry
      start_round(32'hC302_8140);
      play(16'b1000_0100_0010_0001, 1'b0);
      repeat (TO - 1) tick();
      check("timeout_not_yet", 32'(lose), 32'd0);
      tick();
      check("timeout_lose", stat(), 32'b0000_0_0_00_0_1);

      // Correct press on the timeout cycle wins over the timeout
      start_round(32'hC302_8140);
      play(16'b1000_0100_0010_0001, 1'b0);
      repeat (TO - 1) tick();
      check("edge_before_press", 32'(lose), 32'd0);
      press(4'b0001, 0);
      check("edge_press_no_lose", stat(), 32'b0000_1_1_01_0_0);
      repeat (TO - 1) tick();
      check("restart_not_yet", 32'(lose), 32'd0);
      tick();
      check("restart_timeout", stat(), 32'b0000_0_0_01_0_1);

      // Asynchronous reset during SHOW_ON of symbol 2
      start_round(32'hC302_8140);
      repeat (2 * (ON + OFF) + 1) tick();
      check("pre_reset_led", stat(), 32'b0100_1_0_10_0_0);
      #2 reset = 1'b1;
      #1;
      check("async_reset", stat(), 32'h0);
      tick();
      reset = 1'b0;
      repeat (20) tick();
      check("idle_no_activity", stat(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
